// File: rtl/csr_regfile.sv
// rtl/csr_regfile.sv - machine-mode CSR storage, counters and trap/mret state
module csr_regfile #(
    parameter int                     DATA_WIDTH     = 32,
    parameter int                     CSR_ADDR_WIDTH = 12,
    parameter logic [DATA_WIDTH-1:0]  HART_ID        = '0,
    parameter logic [DATA_WIDTH-1:0]  MISA_VAL       = 32'h40000100
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      csr_re_i,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_raddr_i,
    output logic [DATA_WIDTH-1:0]     csr_rdata_o,
    input  logic                      csr_we_i,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i,
    input  logic [DATA_WIDTH-1:0]     csr_wdata_i,
    input  logic                      instret_inc_i,
    input  logic                      trap_valid_i,
    input  logic [DATA_WIDTH-1:0]     trap_pc_i,
    input  logic [DATA_WIDTH-1:0]     trap_cause_i,
    input  logic [DATA_WIDTH-1:0]     trap_val_i,
    input  logic                      mret_i,
    input  logic                      timer_irq_i,
    output logic                      csr_illegal_o,
    output logic [DATA_WIDTH-1:0]     mtvec_o,
    output logic [DATA_WIDTH-1:0]     mepc_o,
    output logic                      mie_global_o
);

    localparam logic [CSR_ADDR_WIDTH-1:0] A_MSTATUS  = 'h300;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MISA     = 'h301;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MIE      = 'h304;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MTVEC    = 'h305;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MSCRATCH = 'h340;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MEPC     = 'h341;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MCAUSE   = 'h342;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MTVAL    = 'h343;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MIP      = 'h344;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MCYCLE   = 'hB00;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MCYCLEH  = 'hB80;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MINSTR   = 'hB02;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MINSTRH  = 'hB82;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_CYCLE    = 'hC00;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_CYCLEH   = 'hC80;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_INSTR    = 'hC02;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_INSTRH   = 'hC82;
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MHARTID  = 'hF14;
    localparam logic [DATA_WIDTH-1:0]     MIE_MASK   = 32'h0000_0888;

    logic                      r_mstatus_mie;
    logic                      r_mstatus_mpie;
    logic [DATA_WIDTH-1:0]     r_mie;
    logic [DATA_WIDTH-1:0]     r_mtvec;
    logic [DATA_WIDTH-1:0]     r_mscratch;
    logic [DATA_WIDTH-1:0]     r_mepc;
    logic [DATA_WIDTH-1:0]     r_mcause;
    logic [DATA_WIDTH-1:0]     r_mtval;
    logic [2*DATA_WIDTH-1:0]   r_mcycle;
    logic [2*DATA_WIDTH-1:0]   r_minstret;

    logic [DATA_WIDTH-1:0]     w_mstatus;
    logic [DATA_WIDTH-1:0]     w_stored;
    logic                      w_mapped;
    logic [DATA_WIDTH-1:0]     w_wr_val;
    logic                      w_wr_ok;
    logic                      w_unused_pc;

    assign w_unused_pc = ^trap_pc_i[1:0];
    assign w_mstatus   = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};

    // Stored view of the read address plus the mapped/unmapped decision.
    always_comb begin
        w_stored = '0;
        w_mapped = 1'b1;
        case (csr_raddr_i)
            A_MSTATUS:  w_stored = w_mstatus;
            A_MISA:     w_stored = MISA_VAL;
            A_MIE:      w_stored = r_mie;
            A_MTVEC:    w_stored = r_mtvec;
            A_MSCRATCH: w_stored = r_mscratch;
            A_MEPC:     w_stored = r_mepc;
            A_MCAUSE:   w_stored = r_mcause;
            A_MTVAL:    w_stored = r_mtval;
            A_MIP:      w_stored = {24'b0, timer_irq_i, 7'b0};
            A_MCYCLE,  A_CYCLE:  w_stored = r_mcycle[DATA_WIDTH-1:0];
            A_MCYCLEH, A_CYCLEH: w_stored = r_mcycle[2*DATA_WIDTH-1:DATA_WIDTH];
            A_MINSTR,  A_INSTR:  w_stored = r_minstret[DATA_WIDTH-1:0];
            A_MINSTRH, A_INSTRH: w_stored = r_minstret[2*DATA_WIDTH-1:DATA_WIDTH];
            A_MHARTID:  w_stored = HART_ID;
            default:    w_mapped = 1'b0;
        endcase
    end

    // Value the write address would read back after its field masks.
    always_comb begin
        w_wr_val = csr_wdata_i;
        w_wr_ok  = 1'b1;
        case (csr_waddr_i)
            A_MSTATUS: w_wr_val = {19'b0, 2'b11, 3'b0, csr_wdata_i[7], 3'b0, csr_wdata_i[3], 3'b0};
            A_MIE:     w_wr_val = csr_wdata_i & MIE_MASK;
            A_MTVEC, A_MEPC: w_wr_val = {csr_wdata_i[DATA_WIDTH-1:2], 2'b00};
            A_MSCRATCH, A_MCAUSE, A_MTVAL,
            A_MCYCLE, A_MCYCLEH, A_MINSTR, A_MINSTRH: w_wr_val = csr_wdata_i;
            default:   w_wr_ok = 1'b0;
        endcase
    end

    always_comb begin
        csr_rdata_o = w_stored;
        if (csr_we_i && w_wr_ok && (csr_waddr_i == csr_raddr_i)) begin
            csr_rdata_o = w_wr_val;
        end
    end

    assign csr_illegal_o = csr_re_i & (~w_mapped |
                           (csr_we_i & (csr_raddr_i == csr_waddr_i) & (csr_raddr_i[11:10] == 2'b11)));

    // Trap beats mret beats CSR write, decided separately for each register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mstatus_mie  <= 1'b0;
            r_mstatus_mpie <= 1'b0;
            r_mie          <= '0;
            r_mtvec        <= '0;
            r_mscratch     <= '0;
            r_mepc         <= '0;
            r_mcause       <= '0;
            r_mtval        <= '0;
            r_mcycle       <= '0;
            r_minstret     <= '0;
        end else begin
            if (trap_valid_i) begin
                r_mstatus_mpie <= r_mstatus_mie;
                r_mstatus_mie  <= 1'b0;
            end else if (mret_i) begin
                r_mstatus_mie  <= r_mstatus_mpie;
                r_mstatus_mpie <= 1'b1;
            end else if (csr_we_i && csr_waddr_i == A_MSTATUS) begin
                r_mstatus_mie  <= csr_wdata_i[3];
                r_mstatus_mpie <= csr_wdata_i[7];
            end

            if (trap_valid_i) begin
                r_mepc   <= {trap_pc_i[DATA_WIDTH-1:2], 2'b00};
                r_mcause <= trap_cause_i;
                r_mtval  <= trap_val_i;
            end else if (csr_we_i) begin
                if (csr_waddr_i == A_MEPC)   r_mepc   <= w_wr_val;
                if (csr_waddr_i == A_MCAUSE) r_mcause <= csr_wdata_i;
                if (csr_waddr_i == A_MTVAL)  r_mtval  <= csr_wdata_i;
            end

            if (csr_we_i && csr_waddr_i == A_MIE)      r_mie      <= w_wr_val;
            if (csr_we_i && csr_waddr_i == A_MTVEC)    r_mtvec    <= w_wr_val;
            if (csr_we_i && csr_waddr_i == A_MSCRATCH) r_mscratch <= csr_wdata_i;

            if (csr_we_i && csr_waddr_i == A_MCYCLE)
                r_mcycle[DATA_WIDTH-1:0] <= csr_wdata_i;
            else if (csr_we_i && csr_waddr_i == A_MCYCLEH)
                r_mcycle[2*DATA_WIDTH-1:DATA_WIDTH] <= csr_wdata_i;
            else
                r_mcycle <= r_mcycle + 1'b1;

            if (csr_we_i && csr_waddr_i == A_MINSTR)
                r_minstret[DATA_WIDTH-1:0] <= csr_wdata_i;
            else if (csr_we_i && csr_waddr_i == A_MINSTRH)
                r_minstret[2*DATA_WIDTH-1:DATA_WIDTH] <= csr_wdata_i;
            else if (instret_inc_i)
                r_minstret <= r_minstret + 1'b1;
        end
    end

    assign mtvec_o      = r_mtvec;
    assign mepc_o       = r_mepc;
    assign mie_global_o = r_mstatus_mie;

endmodule

// File: tb/tb_csr_regfile.sv
// tb/tb_csr_regfile.sv - directed vector bench for csr_regfile
`timescale 1ns/100ps
module tb_csr_regfile;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        csr_re_i;
    logic [11:0] csr_raddr_i;
    logic [31:0] csr_rdata_o;
    logic        csr_we_i;
    logic [11:0] csr_waddr_i;
    logic [31:0] csr_wdata_i;
    logic        instret_inc_i;
    logic        trap_valid_i;
    logic [31:0] trap_pc_i;
    logic [31:0] trap_cause_i;
    logic [31:0] trap_val_i;
    logic        mret_i;
    logic        timer_irq_i;
    logic        csr_illegal_o;
    logic [31:0] mtvec_o;
    logic [31:0] mepc_o;
    logic        mie_global_o;

    int total = 0;
    int bad   = 0;

    always #10 clk_i = ~clk_i;

    csr_regfile dut (
        .clk_i(clk_i), .rst_i(rst_i), .csr_re_i(csr_re_i), .csr_raddr_i(csr_raddr_i),
        .csr_rdata_o(csr_rdata_o), .csr_we_i(csr_we_i), .csr_waddr_i(csr_waddr_i),
        .csr_wdata_i(csr_wdata_i), .instret_inc_i(instret_inc_i), .trap_valid_i(trap_valid_i),
        .trap_pc_i(trap_pc_i), .trap_cause_i(trap_cause_i), .trap_val_i(trap_val_i),
        .mret_i(mret_i), .timer_irq_i(timer_irq_i), .csr_illegal_o(csr_illegal_o),
        .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_global_o(mie_global_o)
    );

    typedef struct {
        logic        re;
        logic        we;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic [11:0] raddr;
        logic [31:0] exp_rdata;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic rd(input string name, input logic [11:0] addr, input logic [31:0] exp);
        csr_re_i    = 1'b1;
        csr_raddr_i = addr;
        #1;
        chk(name, csr_rdata_o, exp);
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] data);
        csr_we_i    = 1'b1;
        csr_waddr_i = addr;
        csr_wdata_i = data;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 12'h340, 32'hDEADBEEF, 12'h340, 32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 12'h000, 32'h0,        12'h340, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 12'h305, 32'h80000003, 12'h300, 32'h00001800, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 12'h000, 32'h0,        12'h305, 32'h80000000, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 12'h340, 32'h12345678, 12'h340, 32'h12345678, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 12'h000, 32'h0,        12'h7C0, 32'h00000000, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 12'hF14, 32'h7,        12'hF14, 32'h00000000, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 12'h000, 32'h0,        12'hF14, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 12'h000, 32'h0,        12'h301, 32'h40000100, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 12'h000, 32'h0,        12'h344, 32'h00000080, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 12'h304, 32'hFFFFFFFF, 12'h304, 32'h00000888, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 12'h300, 32'hFFFFFFFF, 12'h300, 32'h00001888, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 12'h000, 32'h0,        12'h300, 32'h00001888, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 12'h342, 32'h000000A5, 12'h343, 32'h00000000, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 12'h000, 32'h0,        12'h342, 32'h000000A5, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 12'hC00, 32'h5,        12'h304, 32'h00000888, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 12'h000, 32'h0,        12'h7C0, 32'h00000000, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 12'h343, 32'h11223344, 12'h343, 32'h11223344, 1'b0};

        rst_i = 1'b1; csr_re_i = 1'b0; csr_raddr_i = '0; csr_we_i = 1'b0;
        csr_waddr_i = '0; csr_wdata_i = '0; instret_inc_i = 1'b0; trap_valid_i = 1'b0;
        trap_pc_i = '0; trap_cause_i = '0; trap_val_i = '0; mret_i = 1'b0; timer_irq_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("reset_mtvec_o", mtvec_o, 32'h0);
        chk("reset_mie_global", {31'b0, mie_global_o}, 32'h0);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk_i);
            csr_re_i    = vecs[i].re;
            csr_we_i    = vecs[i].we;
            csr_waddr_i = vecs[i].waddr;
            csr_wdata_i = vecs[i].wdata;
            csr_raddr_i = vecs[i].raddr;
            #1;
            chk($sformatf("vec%0d_rdata", i), csr_rdata_o, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_illegal", i), {31'b0, csr_illegal_o}, {31'b0, vecs[i].exp_ill});
        end
        @(negedge clk_i);
        csr_we_i = 1'b0;
        #1;
        chk("mtvec_o", mtvec_o, 32'h80000000);
        chk("mie_global_set", {31'b0, mie_global_o}, 32'h1);

        // trap with a competing mepc write
        @(negedge clk_i);
        trap_valid_i = 1'b1; trap_pc_i = 32'h102; trap_cause_i = 32'hB; trap_val_i = 32'h55;
        wr(12'h341, 32'h400);
        @(negedge clk_i);
        trap_valid_i = 1'b0; csr_we_i = 1'b0;
        rd("trap_mepc", 12'h341, 32'h100);
        chk("trap_mepc_o", mepc_o, 32'h100);
        rd("trap_mcause", 12'h342, 32'hB);
        rd("trap_mtval", 12'h343, 32'h55);
        rd("trap_mstatus", 12'h300, 32'h1880);
        chk("trap_mie_global", {31'b0, mie_global_o}, 32'h0);

        // mret with a competing mstatus write
        @(negedge clk_i);
        mret_i = 1'b1;
        wr(12'h300, 32'h0);
        @(negedge clk_i);
        mret_i = 1'b0; csr_we_i = 1'b0;
        rd("mret_mstatus", 12'h300, 32'h1888);
        chk("mret_mie_global", {31'b0, mie_global_o}, 32'h1);

        // mcycle carry across halves
        @(negedge clk_i);
        wr(12'hB00, 32'hFFFFFFFE);
        @(negedge clk_i);
        wr(12'hB80, 32'h0);
        @(negedge clk_i);
        csr_we_i = 1'b0;
        rd("carry_lo0", 12'hB00, 32'hFFFFFFFE);
        rd("carry_hi0", 12'hB80, 32'h0);
        @(negedge clk_i);
        rd("carry_lo1", 12'hB00, 32'hFFFFFFFF);
        @(negedge clk_i);
        rd("carry_hi2", 12'hB80, 32'h1);
        rd("carry_lo2", 12'hB00, 32'h0);
        rd("carry_cycleh", 12'hC80, 32'h1);

        // minstret pulses and wrap
        repeat (3) begin
            @(negedge clk_i); instret_inc_i = 1'b1;
            @(negedge clk_i); instret_inc_i = 1'b0;
        end
        rd("instret_shadow", 12'hC02, 32'h3);
        rd("instret_lo", 12'hB02, 32'h3);
        rd("instret_hi", 12'hC82, 32'h0);
        @(negedge clk_i);
        wr(12'hB02, 32'hFFFFFFFF);
        @(negedge clk_i);
        wr(12'hB82, 32'hFFFFFFFF);
        @(negedge clk_i);
        csr_we_i = 1'b0; instret_inc_i = 1'b1;
        rd("instret_max_lo", 12'hB02, 32'hFFFFFFFF);
        rd("instret_max_hi", 12'hB82, 32'hFFFFFFFF);
        @(negedge clk_i);
        instret_inc_i = 1'b0;
        rd("instret_wrap_lo", 12'hB02, 32'h0);
        rd("instret_wrap_hi", 12'hB82, 32'h0);

        timer_irq_i = 1'b0;
        rd("mip_clear", 12'h344, 32'h0);

        // reset mid-run
        @(negedge clk_i);
        wr(12'hB00, 32'h1234);
        @(negedge clk_i);
        csr_we_i = 1'b0;
        rd("pre_reset_mcycle", 12'hB00, 32'h1234);
        rst_i = 1'b1;
        rd("rst_mcycle", 12'hB00, 32'h0);
        rd("rst_mtvec", 12'h305, 32'h0);
        rd("rst_mscratch", 12'h340, 32'h0);
        rd("rst_mstatus", 12'h300, 32'h1800);
        rd("rst_misa", 12'h301, 32'h40000100);
        chk("rst_mtvec_o", mtvec_o, 32'h0);
        chk("rst_mepc_o", mepc_o, 32'h0);
        chk("rst_mie_global", {31'b0, mie_global_o}, 32'h0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        rd("post_rst_c0", 12'hB00, 32'h0);
        @(negedge clk_i);
        rd("post_rst_c1", 12'hB00, 32'h1);
        @(negedge clk_i);
        rd("post_rst_c2", 12'hB00, 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/csr_regfile.md
Name: csr_regfile

Overview:
- Machine-mode CSR storage for the RV32 pipeline.
- Answers the CSR read address and returns the old CSR value; the decode/execute path uses that value for CSRRW/CSRRS/CSRRC.
- Takes CSR writes (address, data, enable) from the execute stage.
- Runs the mcycle/minstret counters and the trap/mret state updates.
- Exports mtvec, mepc and the global interrupt enable to the control path.

Parameters:
- DATA_WIDTH, 32, CSR data width.
- CSR_ADDR_WIDTH, 12, CSR address width.
- HART_ID, 0, value read at mhartid.
- MISA_VAL, 32'h40000100, read-only misa value (RV32I).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- csr_re_i  in  1  a CSR read is in progress (used only for the illegal flag).
- csr_raddr_i  in  12  read address.
- csr_rdata_o  out  32  read data, combinational.
- csr_we_i  in  1  write enable from exe.
- csr_waddr_i  in  12  write address.
- csr_wdata_i  in  32  final value to write (RS/RC merge already done in exe).
- instret_inc_i  in  1  one instruction retired this cycle.
- trap_valid_i  in  1  trap taken this cycle.
- trap_pc_i  in  32  pc of the trapping instruction.
- trap_cause_i  in  32  mcause value for the trap.
- trap_val_i  in  32  mtval value for the trap.
- mret_i  in  1  mret retiring this cycle.
- timer_irq_i  in  1  timer interrupt level; shown as mip.MTIP (bit 7).
- csr_illegal_o  out  1  access to an unmapped CSR.
- mtvec_o  out  32  current mtvec.
- mepc_o  out  32  current mepc.
- mie_global_o  out  1  mstatus.MIE.

Behaviour:
- Reset (asynchronous, rst_i=1): all storage is 0.
  - mcycle = 0, minstret = 0.
  - mtvec_o = 0, mepc_o = 0, mie_global_o = 0.
  - csr_rdata_o still follows the read mux (constant CSRs stay visible).
- Reset mid-operation clears all state immediately. Counters restart from 0 on the first clock edge after rst_i falls.
- Address map (any other address reads 0 and is unmapped):
  - 0x300 mstatus: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - 0x301 misa: returns MISA_VAL.
  - 0x304 mie: bits 3, 7 and 11 are writable.
  - 0x305 mtvec: bits [1:0] forced to 0.
  - 0x340 mscratch: full 32 bits.
  - 0x341 mepc: bits [1:0] forced to 0.
  - 0x342 mcause, 0x343 mtval: full 32 bits.
  - 0x344 mip: read-only, {24'b0, timer_irq_i, 7'b0}.
  - 0xB00/0xB80 mcycle low/high and 0xB02/0xB82 minstret low/high: read/write.
  - 0xC00/0xC80 and 0xC02/0xC82: read-only shadows of mcycle and minstret.
  - 0xF14 mhartid: returns HART_ID.
- Read path, combinational, zero latency:
  - If csr_we_i=1 and csr_waddr_i==csr_raddr_i, csr_rdata_o shows csr_wdata_i after the field masks (write-through bypass).
  - Otherwise csr_rdata_o is the stored value.
- csr_illegal_o = csr_re_i & (unmapped(csr_raddr_i) | (csr_we_i & csr_raddr_i==csr_waddr_i & csr_raddr_i[11:10]==2'b11)).
- Writes:
  - Committed on the rising edge when csr_we_i=1.
  - Writes to read-only or unmapped addresses are dropped.
- Counters (64-bit, wrap from 2^64-1 to 0):
  - mcycle adds 1 every cycle.
  - minstret adds 1 when instret_inc_i=1.
  - A CSR write to a counter half wins over that cycle's increment, for the whole 64-bit counter; the other half keeps its value. Example: write 0xB00 = 5 gives mcycle = {old_hi, 5} next cycle; the cycle after it reads 6.
- Trap (trap_valid_i=1) at the clock edge:
  - mepc <= {trap_pc_i[31:2], 2'b00}.
  - mcause <= trap_cause_i, mtval <= trap_val_i.
  - MPIE <= MIE, MIE <= 0.
- mret (mret_i=1, trap_valid_i=0): MIE <= MPIE, MPIE <= 1.
- Same-cycle priority: trap_valid_i > mret_i > csr_we_i, applied per register.
  - A CSR write to mepc/mcause/mtval/mstatus in a trap cycle is lost.
  - A CSR write to mstatus in an mret cycle is lost.
  - CSR writes to other registers in that cycle still commit.
- Outputs mtvec_o, mepc_o and mie_global_o come straight from the registers: updated one cycle after the write, no bypass.

Test Plan:
- Reset: assert rst_i mid-run with mcycle=0x1234 -> mcycle and mtvec read 0 at once. After release, 0xB00 reads 0, 1, 2 on successive cycles.
- Write/read: write 0x340 = 0xDEADBEEF, then read 0x340 -> 0xDEADBEEF. Write 0x305 = 0x80000003 -> reads 0x80000000 and mtvec_o = 0x80000000 next cycle. Same-cycle read of 0x340 while writing 0x12345678 -> 0x12345678.
- Counter carry: write 0xB00 = 0xFFFFFFFE, 0xB80 = 0 -> two cycles later 0xB80 reads 1 and 0xB00 reads 0. Pulse instret_inc_i 3 times -> 0xC02 reads 3.
- Trap/mret: MIE=1, then trap pc = 0x102, cause = 0xB, val = 0x55 -> mepc = 0x100, mcause = 0xB, mtval = 0x55, mstatus = 0x1880. Then mret -> mstatus = 0x1888.
- Conflict: trap and csr write to mepc = 0x400 in the same cycle -> mepc = trap value. mret plus a write to mstatus = 0 -> MIE = old MPIE.
- Illegal/read-only: read 0x7C0 -> data 0, csr_illegal_o = 1. Write 0xF14 = 7 -> still reads HART_ID. mip reads 0x80 while timer_irq_i = 1.
